flash_reader: RTL

//   Bus-master sequencer that drives the flash register interface (CS!, DO!, DR?, DI@) to perform
//   SPI READ (0x03) bursts. Accepts {address, length} requests from the CPU/loader side, emits the

---
 rtl/flash_reader.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/flash_reader.sv
// SPI READ burst sequencer on the flash register bus; streams read bytes out over valid/ready.
// Optional wake frame (0xAB + settle delay) before the first burst after reset: FLASH_READER_WAKE_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for i_req
//   CS_OFF  | write CS=0 (release, guarantees a clean frame start)
//   CS_ON   | write CS=1 (assert)
//   TX      | write DO with header / dummy / wake byte
//   GAP     | one idle cycle before status polling
//   POLL    | read DR
//   PCHK    | test DR bit 0; loop to POLL until set
//   RD      | read DI
//   CAP     | latch DI read data into the output byte
//   OUT     | present byte, wait for i_ready
//   END     | write CS=0 (release)
//   WAIT    | wake settle delay (wake build only)
//   DONE    | o_done pulse
module flash_reader #(
    parameter int          LEN_W       = 16,
    parameter logic [7:0]  CMD_READ    = 8'h03,
    parameter int          WAKE_CYCLES = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic [23:0]      i_faddr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_valid,
    output logic [7:0]       o_data,
    input  logic             i_ready,
    output logic             o_en,
    output logic             o_wr,
    output logic [3:0]       o_addr,
    output logic [7:0]       o_wdata,
    input  logic [7:0]       i_rdata
);

    localparam logic [3:0] REG_CS = 4'd0;
    localparam logic [3:0] REG_DO = 4'd1;
    localparam logic [3:0] REG_DR = 4'd2;
    localparam logic [3:0] REG_DI = 4'd3;
    localparam logic [7:0] CMD_WAKE = 8'hAB;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_OFF,
        ST_CS_ON,
        ST_TX,
        ST_GAP,
        ST_POLL,
        ST_PCHK,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_END,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        faddr_q, faddr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [1:0]         hdr_idx_q, hdr_idx_d;
    logic               data_ph_q, data_ph_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         tx_byte;
    logic               wake_pend;
    logic               wait_done;

`ifdef FLASH_READER_WAKE_EN
    localparam int WAIT_W = $clog2(WAKE_CYCLES + 1);

    logic              wake_pend_q, wake_pend_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Down-counter reloads whenever the FSM is outside WAIT; the pending flag
    // drops at terminal count so the following CS_OFF starts the real burst.
    always_comb begin
        wake_pend_d = wake_pend_q;
        wait_cnt_d  = WAIT_W'(WAKE_CYCLES - 1);
        if (state_q == ST_WAIT) begin
            if (wait_cnt_q != '0) begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end else begin
                wait_cnt_d  = '0;
                wake_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wake_pend_q <= 1'b1;
            wait_cnt_q  <= '0;
        end else begin
            wake_pend_q <= wake_pend_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign wake_pend = wake_pend_q;
    assign wait_done = (wait_cnt_q == '0);
`else
    assign wake_pend = 1'b0;
    assign wait_done = 1'b1;
`endif

    always_comb begin
        tx_byte = 8'h00;
        if (wake_pend) begin
            tx_byte = CMD_WAKE;
        end else if (!data_ph_q) begin
            case (hdr_idx_q)
                2'd0:    tx_byte = CMD_READ;
                2'd1:    tx_byte = faddr_q[23:16];
                2'd2:    tx_byte = faddr_q[15:8];
                default: tx_byte = faddr_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        faddr_d   = faddr_q;
        rem_d     = rem_q;
        hdr_idx_d = hdr_idx_q;
        data_ph_d = data_ph_q;
        data_d    = data_q;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        o_valid   = 1'b0;
        o_en      = 1'b0;
        o_wr      = 1'b0;
        o_addr    = REG_CS;
        o_wdata   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_req) begin
                    faddr_d   = i_faddr;
                    rem_d     = i_len;
                    hdr_idx_d = 2'd0;
                    data_ph_d = 1'b0;
                    state_d   = (i_len == '0) ? ST_DONE : ST_CS_OFF;
                end
            end
            ST_CS_OFF: begin
                o_en    = 1'b1;
                o_wr    = 1'b1;
                o_addr  = REG_CS;
                o_wdata = 8'h00;
                state_d = ST_CS_ON;
            end
            ST_CS_ON: begin
                o_en    = 1'b1;
                o_wr    = 1'b1;
                o_addr  = REG_CS;
                o_wdata = 8'h01;
                state_d = ST_TX;
            end
            ST_TX: begin
                o_en    = 1'b1;
                o_wr    = 1'b1;
                o_addr  = REG_DO;
                o_wdata = tx_byte;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_POLL;
            end
            ST_POLL: begin
                o_en    = 1'b1;
                o_addr  = REG_DR;
                state_d = ST_PCHK;
            end
            ST_PCHK: begin
                if (!i_rdata[0]) begin
                    state_d = ST_POLL;
                end else if (wake_pend) begin
                    state_d = ST_END;
                end else if (data_ph_q) begin
                    state_d = ST_RD;
                end else if (hdr_idx_q == 2'd3) begin
                    data_ph_d = 1'b1;
                    state_d   = ST_TX;
                end else begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    state_d   = ST_TX;
                end
            end
            ST_RD: begin
                o_en    = 1'b1;
                o_addr  = REG_DI;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                data_d  = i_rdata;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                o_valid = 1'b1;
                // No skid buffer: the next DO write waits for this byte to leave.
                if (i_ready) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                    state_d = (rem_q <= LEN_W'(1)) ? ST_END : ST_TX;
                end
            end
            ST_END: begin
                o_en    = 1'b1;
                o_wr    = 1'b1;
                o_addr  = REG_CS;
                o_wdata = 8'h00;
                state_d = wake_pend ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_d = ST_CS_OFF;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            faddr_q   <= '0;
            rem_q     <= '0;
            hdr_idx_q <= '0;
            data_ph_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            faddr_q   <= faddr_d;
            rem_q     <= rem_d;
            hdr_idx_q <= hdr_idx_d;
            data_ph_q <= data_ph_d;
            data_q    <= data_d;
        end
    end

    assign o_data = data_q;

endmodule
